product_accumulator: RTL and testbench

Sequential accumulator sitting directly downstream of the 8×8 combinational array multiplier. Accepts a burst of 16-bit products over a valid/ready handshake, sums a programmable number of them into a wider accumulator, and presents the registered total on an output valid/ready port. Serves as the reduction stage for dot-product and FIR datapaths built on the multiplier.

---
 rtl/product_accumulator.sv | 127 ++++++++++++
 tb/tb_product_accumulator.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Reduction stage that sums a burst of unsigned multiplier products into a wider accumulator.
// Define PRODUCT_ACCUMULATOR_SAT_EN to clamp the sum at its maximum instead of wrapping.
module product_accumulator #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int LEN_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_clear,
  input  logic [LEN_W-1:0]  io_len,
  input  logic              io_in_valid,
  output logic              io_in_ready,
  input  logic [PROD_W-1:0] io_in_bits,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [ACC_W-1:0]  io_out_bits,
  output logic              io_out_overflow,
  output logic              io_busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_e;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};
`endif

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               ovf_q, ovf_d;
  logic               in_ready_q, in_ready_d;

  logic               in_fire_s;
  logic [ACC_W:0]     sum_s;
  logic               carry_s;

  assign in_fire_s = io_in_valid && in_ready_q;
  assign sum_s     = {1'b0, acc_q} + (ACC_W+1)'(io_in_bits);
  assign carry_s   = sum_s[ACC_W];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    if (io_clear) begin
      state_d = IDLE;
      acc_d   = '0;
      rem_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_fire_s) begin
            acc_d   = ACC_W'(io_in_bits);
            // A length of zero wraps to the full 2^LEN_W burst here.
            rem_d   = io_len - LEN_ONE;
            ovf_d   = 1'b0;
            state_d = (io_len == LEN_ONE) ? OUTPUT : ACCUM;
          end else begin
            state_d = IDLE;
          end
        end
        ACCUM: begin
          if (in_fire_s) begin
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
            acc_d = carry_s ? ACC_MAX : sum_s[ACC_W-1:0];
`else
            acc_d = sum_s[ACC_W-1:0];
`endif
            ovf_d = ovf_q | carry_s;
            rem_d = rem_q - LEN_ONE;
            if (rem_q == LEN_ONE) begin
              state_d = OUTPUT;
            end else begin
              state_d = ACCUM;
            end
          end else begin
            state_d = ACCUM;
          end
        end
        OUTPUT: begin
          if (io_out_ready) begin
            state_d = IDLE;
          end else begin
            state_d = OUTPUT;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // in_ready is registered so it stays low while reset is held.
  assign in_ready_d = (state_d != OUTPUT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      rem_q      <= '0;
      ovf_q      <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      ovf_q      <= ovf_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign io_in_ready     = in_ready_q;
  assign io_out_valid    = (state_q == OUTPUT);
  assign io_out_bits     = acc_q;
  assign io_out_overflow = ovf_q;
  assign io_busy         = (state_q != IDLE);

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator; a second ACC_W=16 instance exercises overflow.
module tb_product_accumulator;

  typedef struct packed {
    logic [23:0] bits;
    logic        ovf;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        io_clear;
  logic [7:0]  io_len;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [15:0] io_in_bits;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [23:0] io_out_bits;
  logic        io_out_overflow;
  logic        io_busy;

  logic        in_ready16;
  logic        out_valid16;
  logic [15:0] out_bits16;
  logic        overflow16;
  logic        busy16;

  exp_t sb[$];
  exp_t e;
  int   tests_run;
  int   tests_failed;
  int   beat_timeouts;

  product_accumulator #(.PROD_W(16), .ACC_W(24), .LEN_W(8)) dut (
    .clock(clock), .reset(reset), .io_clear(io_clear), .io_len(io_len),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready), .io_in_bits(io_in_bits),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready), .io_out_bits(io_out_bits),
    .io_out_overflow(io_out_overflow), .io_busy(io_busy)
  );

  product_accumulator #(.PROD_W(16), .ACC_W(16), .LEN_W(8)) dut16 (
    .clock(clock), .reset(reset), .io_clear(io_clear), .io_len(io_len),
    .io_in_valid(io_in_valid), .io_in_ready(in_ready16), .io_in_bits(io_in_bits),
    .io_out_valid(out_valid16), .io_out_ready(io_out_ready), .io_out_bits(out_bits16),
    .io_out_overflow(overflow16), .io_busy(busy16)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Present one beat and hold it until the edge where it is accepted.
  task automatic send_beat(input logic [15:0] b);
    int n;
    n = 0;
    io_in_valid = 1'b1;
    io_in_bits  = b;
    while (!io_in_ready && n < 64) begin
      @(posedge clock); #1;
      n++;
    end
    if (!io_in_ready) beat_timeouts++;
    @(posedge clock); #1;
    io_in_valid = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    tests_run++;
    if (io_in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready got=%0b want=0", io_in_ready); end
    tests_run++;
    if (io_out_valid !== 1'b0 || io_busy !== 1'b0 || io_out_overflow !== 1'b0) begin
      tests_failed++; $display("FAIL reset_flags got valid=%0b busy=%0b ovf=%0b want 0,0,0", io_out_valid, io_busy, io_out_overflow);
    end
    tests_run++;
    if (io_out_bits !== 24'd0) begin tests_failed++; $display("FAIL reset_bits got=%0d want=0", io_out_bits); end
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    tests_run++;
    if (io_in_ready !== 1'b1 || io_busy !== 1'b0) begin
      tests_failed++; $display("FAIL reset_release got ready=%0b busy=%0b want 1,0", io_in_ready, io_busy);
    end
  endtask

  task automatic test_basic;
    logic [15:0] v [4];
    v = '{16'd3, 16'd10, 16'd200, 16'd65025};
    io_len = 8'd4;
    io_out_ready = 1'b1;
    sb.push_back('{bits: 24'd65238, ovf: 1'b0});
    for (int i = 0; i < 4; i++) begin
      send_beat(v[i]);
      if (i < 3) begin
        tests_run++;
        if (io_out_valid !== 1'b0 || io_busy !== 1'b1) begin
          tests_failed++; $display("FAIL basic_mid beat=%0d got valid=%0b busy=%0b want 0,1", i, io_out_valid, io_busy);
        end
      end
    end
    tests_run++;
    if (io_out_valid !== 1'b1 || io_in_ready !== 1'b0) begin
      tests_failed++; $display("FAIL basic_latency got valid=%0b ready=%0b want 1,0", io_out_valid, io_in_ready);
    end
    e = sb.pop_front();
    tests_run++;
    if (io_out_bits !== e.bits || io_out_overflow !== e.ovf) begin
      tests_failed++; $display("FAIL basic_sum got=%0d/%0b want=%0d/%0b", io_out_bits, io_out_overflow, e.bits, e.ovf);
    end
    @(posedge clock); #1;
    tests_run++;
    if (io_out_valid !== 1'b0 || io_in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL basic_one_cycle got valid=%0b ready=%0b want 0,1", io_out_valid, io_in_ready);
    end
  endtask

  task automatic test_lengths;
    io_len = 8'd1;
    sb.push_back('{bits: 24'h00FFFF, ovf: 1'b0});
    send_beat(16'hFFFF);
    e = sb.pop_front();
    tests_run++;
    if (io_out_valid !== 1'b1 || io_out_bits !== e.bits || io_out_overflow !== e.ovf) begin
      tests_failed++; $display("FAIL len1 got valid=%0b bits=%0h ovf=%0b want 1/%0h/%0b", io_out_valid, io_out_bits, io_out_overflow, e.bits, e.ovf);
    end
    @(posedge clock); #1;
    io_len = 8'd0;
    sb.push_back('{bits: 24'd16646400, ovf: 1'b0});
    for (int i = 0; i < 256; i++) begin
      send_beat(16'd65025);
      if (i == 254) begin
        tests_run++;
        if (io_out_valid !== 1'b0) begin tests_failed++; $display("FAIL len0_early got valid=%0b want 0", io_out_valid); end
      end
      if (i == 0) io_len = 8'd3;
    end
    e = sb.pop_front();
    tests_run++;
    if (io_out_valid !== 1'b1 || io_out_bits !== e.bits || io_out_overflow !== e.ovf) begin
      tests_failed++; $display("FAIL len0 got valid=%0b bits=%0d ovf=%0b want 1/%0d/%0b", io_out_valid, io_out_bits, io_out_overflow, e.bits, e.ovf);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_backpressure;
    io_len = 8'd2;
    io_out_ready = 1'b0;
    sb.push_back('{bits: 24'd12, ovf: 1'b0});
    send_beat(16'd5);
    send_beat(16'd7);
    e = sb.pop_front();
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if (io_out_valid !== 1'b1 || io_in_ready !== 1'b0 || io_out_bits !== e.bits) begin
        tests_failed++; $display("FAIL bp_hold cyc=%0d got valid=%0b ready=%0b bits=%0d want 1/0/%0d", i, io_out_valid, io_in_ready, io_out_bits, e.bits);
      end
      @(posedge clock); #1;
    end
    io_out_ready = 1'b1;
    @(posedge clock); #1;
    tests_run++;
    if (io_out_valid !== 1'b0 || io_in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL bp_release got valid=%0b ready=%0b want 0,1", io_out_valid, io_in_ready);
    end
  endtask

  task automatic test_overflow;
    logic [15:0] want16;
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
    want16 = 16'hFFFF;
`else
    want16 = 16'h0001;
`endif
    io_len = 8'd2;
    sb.push_back('{bits: 24'h010001, ovf: 1'b0});
    send_beat(16'hFFFF);
    send_beat(16'h0002);
    tests_run++;
    if (out_valid16 !== 1'b1 || in_ready16 !== 1'b0 || busy16 !== 1'b1) begin
      tests_failed++; $display("FAIL ovf16_state got valid=%0b ready=%0b busy=%0b want 1,0,1", out_valid16, in_ready16, busy16);
    end
    tests_run++;
    if (out_bits16 !== want16 || overflow16 !== 1'b1) begin
      tests_failed++; $display("FAIL ovf16_sum got=%0h/%0b want=%0h/1", out_bits16, overflow16, want16);
    end
    e = sb.pop_front();
    tests_run++;
    if (io_out_bits !== e.bits || io_out_overflow !== e.ovf) begin
      tests_failed++; $display("FAIL ovf24_sum got=%0h/%0b want=%0h/%0b", io_out_bits, io_out_overflow, e.bits, e.ovf);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_clear;
    io_len = 8'd4;
    send_beat(16'd3);
    send_beat(16'd4);
    io_in_valid = 1'b1;
    io_in_bits  = 16'd100;
    io_clear    = 1'b1;
    @(posedge clock); #1;
    io_clear    = 1'b0;
    io_in_valid = 1'b0;
    tests_run++;
    if (io_busy !== 1'b0 || io_in_ready !== 1'b1 || io_out_valid !== 1'b0 || io_out_bits !== 24'd0) begin
      tests_failed++; $display("FAIL clear_state got busy=%0b ready=%0b valid=%0b bits=%0d want 0/1/0/0", io_busy, io_in_ready, io_out_valid, io_out_bits);
    end
    io_len = 8'd1;
    sb.push_back('{bits: 24'd9, ovf: 1'b0});
    send_beat(16'd9);
    e = sb.pop_front();
    tests_run++;
    if (io_out_valid !== 1'b1 || io_out_bits !== e.bits || io_out_overflow !== e.ovf) begin
      tests_failed++; $display("FAIL clear_next got valid=%0b bits=%0d ovf=%0b want 1/%0d/%0b", io_out_valid, io_out_bits, io_out_overflow, e.bits, e.ovf);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_async_reset;
    io_len = 8'd2;
    send_beat(16'd50);
    tests_run++;
    if (io_busy !== 1'b1 || io_out_bits !== 24'd50) begin
      tests_failed++; $display("FAIL rst_pre got busy=%0b bits=%0d want 1/50", io_busy, io_out_bits);
    end
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (io_busy !== 1'b0 || io_out_valid !== 1'b0 || io_out_bits !== 24'd0 || io_in_ready !== 1'b0) begin
      tests_failed++; $display("FAIL rst_async got busy=%0b valid=%0b bits=%0d ready=%0b want 0/0/0/0", io_busy, io_out_valid, io_out_bits, io_in_ready);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    sb.push_back('{bits: 24'd2, ovf: 1'b0});
    send_beat(16'd1);
    send_beat(16'd1);
    e = sb.pop_front();
    tests_run++;
    if (io_out_valid !== 1'b1 || io_out_bits !== e.bits || io_out_overflow !== e.ovf) begin
      tests_failed++; $display("FAIL rst_next got valid=%0b bits=%0d ovf=%0b want 1/%0d/%0b", io_out_valid, io_out_bits, io_out_overflow, e.bits, e.ovf);
    end
    @(posedge clock); #1;
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    beat_timeouts = 0;
    reset         = 1'b1;
    io_clear      = 1'b0;
    io_len        = 8'd0;
    io_in_valid   = 1'b0;
    io_in_bits    = 16'd0;
    io_out_ready  = 1'b1;
    test_reset();
    test_basic();
    test_lengths();
    test_backpressure();
    test_overflow();
    test_clear();
    test_async_reset();
    tests_run++;
    if (beat_timeouts !== 0 || sb.size() !== 0) begin
      tests_failed++; $display("FAIL final got timeouts=%0d pending=%0d want 0/0", beat_timeouts, sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
